// File: rtl/load_addr_queue_pkg.sv
// load_addr_queue_pkg: shared system definitions for the load path (LB_PACKET, widths, booleans)
//   XLEN        - address width
//   ROB_TAG_LEN - reorder-buffer tag width
//   LB_PACKET   - packet handed from the ACU to the load buffer
package load_addr_queue_pkg;
    localparam int XLEN = 32;
    localparam int ROB_TAG_LEN = 5;
    localparam logic TRUE = 1'b1;
    localparam logic FALSE = 1'b0;
    typedef struct packed {
        logic valid;
        logic speculative;
        logic [ROB_TAG_LEN-1:0] rd_tag;
        logic [XLEN-1:0] address;
    } LB_PACKET;
endpackage

// File: rtl/load_addr_queue_if.sv
// load_addr_queue_if: ACU / load-buffer / branch signals around the load address queue
//   acu_packet_in, acu_stall          - ACU enqueue side
//   lb_full, alloc_enable, lb_packet_out - load buffer handoff side
//   kill, resolve                      - branch outcome
//   empty, count                       - occupancy status
//   slave modport: the queue; master modport: its environment
import load_addr_queue_pkg::*;

interface load_addr_queue_if #(parameter int DEPTH = 4);
    LB_PACKET acu_packet_in;
    logic acu_stall;
    logic lb_full;
    logic alloc_enable;
    LB_PACKET lb_packet_out;
    logic kill;
    logic resolve;
    logic empty;
    logic [$clog2(DEPTH+1)-1:0] count;
    modport slave (
        input acu_packet_in, lb_full, kill, resolve,
        output acu_stall, alloc_enable, lb_packet_out, empty, count
    );
    modport master (
        output acu_packet_in, lb_full, kill, resolve,
        input acu_stall, alloc_enable, lb_packet_out, empty, count
    );
endinterface

// File: rtl/load_addr_queue_oldest_spec_finder.sv
// oldest_spec_finder: locates the oldest valid speculative entry in circular order from head
//   spec, valid - per-entry speculative and valid bits
//   head        - index of the oldest queued entry
//   found       - some valid entry is speculative
//   idx         - index of the oldest such entry (head when none)
import load_addr_queue_pkg::*;

module oldest_spec_finder #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] spec,
    input  logic [DEPTH-1:0] valid,
    input  logic [PW-1:0]    head,
    output logic             found,
    output logic [PW-1:0]    idx
);
    logic [PW-1:0] p;
    // Scan youngest to oldest so the last hit is the one closest to head.
    always_comb begin
        found = FALSE;
        idx = head;
        p = head;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            p = head + PW'(k);
            if (spec[p] && valid[p]) begin
                found = TRUE;
                idx = p;
            end
        end
    end
endmodule

// File: rtl/load_addr_queue.sv
// load_addr_queue: in-order FIFO of ready load packets between the ACU and the load buffer
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   q     - slave side of load_addr_queue_if (ACU enqueue, load buffer offer, kill/resolve, status)
import load_addr_queue_pkg::*;

module load_addr_queue #(parameter int DEPTH = 4) (
    input logic clock,
    input logic reset,
    load_addr_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    LB_PACKET mem [DEPTH];
    LB_PACKET head_pkt, enq_pkt, out_pkt;
    logic [PW-1:0] head, tail, spec_idx, spec_dist, tail_base;
    logic [CW-1:0] cnt, cnt_base;
    logic [DEPTH-1:0] spec_vec, valid_vec;
    logic spec_found, kill_cut, deq, enq, do_resolve, empty;

    for (genvar i = 0; i < DEPTH; i++) begin : g_vec
        assign spec_vec[i] = mem[i].speculative;
        assign valid_vec[i] = mem[i].valid;
    end

    oldest_spec_finder #(.DEPTH(DEPTH)) u_finder (
        .spec(spec_vec),
        .valid(valid_vec),
        .head(head),
        .found(spec_found),
        .idx(spec_idx)
    );

    assign empty = cnt == '0;
    assign head_pkt = mem[head];
    assign q.empty = empty;
    assign q.count = cnt;
    assign q.acu_stall = cnt == CW'(DEPTH);
    assign q.alloc_enable = !empty && !(q.kill && head_pkt.speculative);
    assign q.lb_packet_out = out_pkt;
    assign deq = q.alloc_enable && !q.lb_full;
    assign enq = q.acu_packet_in.valid && !q.acu_stall && !(q.kill && q.acu_packet_in.speculative);
    assign do_resolve = q.resolve && !q.kill;
    // Speculative entries form a run ending at tail, so a kill truncates the queue at the oldest one.
    assign kill_cut = q.kill && spec_found;
    assign spec_dist = spec_idx - head;
    assign tail_base = kill_cut ? spec_idx : tail;
    assign cnt_base = kill_cut ? CW'(spec_dist) : cnt;

    always_comb begin
        out_pkt = empty ? '0 : head_pkt;
        out_pkt.speculative = out_pkt.speculative && !q.resolve;
    end

    always_comb begin
        enq_pkt = q.acu_packet_in;
        enq_pkt.valid = TRUE;
        enq_pkt.speculative = q.acu_packet_in.speculative && !do_resolve;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_resolve) mem[i].speculative <= FALSE;
                if (q.kill && mem[i].speculative) mem[i].valid <= FALSE;
            end
            if (deq) mem[head].valid <= FALSE;
            if (enq) mem[tail_base] <= enq_pkt;
            head <= head + PW'(deq);
            tail <= tail_base + PW'(enq);
            cnt <= cnt_base - CW'(deq) + CW'(enq);
        end
    end
endmodule
